em_stage_reg: RTL and testbench

- E-to-M pipeline register of the 5-stage MIPS core.
- Sits directly downstream of the E-stage ALU and multiply/divide unit. It captures the E result, selecting HI/LO for mfhi/mflo, and merges E-stage exceptions into the carried exception code.
- Inserts bubbles while E is stalled (MDU busy or a hazard) and flushes on a CP0 exception/interrupt request.
- Carries PC and the delay-slot flag through bubbles so CP0 always sees a valid macroscopic PC.

---
 rtl/em_stage_reg.sv | 138 +++++++++++++
 tb/tb_em_stage_reg.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/em_stage_reg.sv
// rtl/em_stage_reg.sv - E-to-M pipeline register with result select, exception merge, bubble and flush
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req                 CP0 exception/interrupt request; flushes the slot to the handler PC
//   bubble              E is stalled; M receives a bubble that still carries E_pc/E_bd
//   E_*                 E-stage instruction, datapath results, MDU HI/LO and control flags
//   M_*                 registered M-stage slot: PC, instr, bd, merged exception code,
//                       selected result, store data, destination, load/store flags,
//                       decremented tnew and valid flag
module em_stage_reg #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [4:0]  EXC_OV     = 5'd12,
    parameter logic [4:0]  EXC_ADEL   = 5'd4,
    parameter logic [4:0]  EXC_ADES   = 5'd5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        bubble,
    input  logic [31:0] E_pc,
    input  logic [31:0] E_instr,
    input  logic        E_bd,
    input  logic [4:0]  E_exc,
    input  logic [31:0] E_alu_res,
    input  logic        E_alu_ov,
    input  logic        E_ov_trap,
    input  logic        E_is_load,
    input  logic        E_is_store,
    input  logic [1:0]  E_res_sel,
    input  logic [31:0] E_HI,
    input  logic [31:0] E_LO,
    input  logic [31:0] E_rt_data,
    input  logic [4:0]  E_wa,
    input  logic [1:0]  E_tnew,
    output logic [31:0] M_pc,
    output logic [31:0] M_instr,
    output logic        M_bd,
    output logic [4:0]  M_exc,
    output logic [31:0] M_res,
    output logic [31:0] M_rt_data,
    output logic [4:0]  M_wa,
    output logic        M_is_load,
    output logic        M_is_store,
    output logic [1:0]  M_tnew,
    output logic        M_valid
);

    logic [4:0]  exc_merged;
    logic [31:0] res_next;
    logic [1:0]  tnew_next;
    logic        has_exc;

    // An exception already raised upstream is older than anything E detects,
    // so it wins; E's own overflow is then classified by instruction kind.
    always_comb begin
        exc_merged = 5'd0;
        if (E_exc != 5'd0) begin
            exc_merged = E_exc;
        end else if (E_alu_ov && E_ov_trap) begin
            exc_merged = EXC_OV;
        end else if (E_alu_ov && E_is_load) begin
            exc_merged = EXC_ADEL;
        end else if (E_alu_ov && E_is_store) begin
            exc_merged = EXC_ADES;
        end
    end

    always_comb begin
        res_next = E_alu_res;
        case (E_res_sel)
            2'd0:    res_next = E_alu_res;
            2'd1:    res_next = E_HI;
            2'd2:    res_next = E_LO;
            default: res_next = E_pc + 32'd8;
        endcase
    end

    assign tnew_next = (E_tnew == 2'd0) ? 2'd0 : E_tnew - 2'd1;
    assign has_exc   = (exc_merged != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            M_pc       <= 32'd0;
            M_instr    <= 32'd0;
            M_bd       <= 1'b0;
            M_exc      <= 5'd0;
            M_res      <= 32'd0;
            M_rt_data  <= 32'd0;
            M_wa       <= 5'd0;
            M_is_load  <= 1'b0;
            M_is_store <= 1'b0;
            M_tnew     <= 2'd0;
            M_valid    <= 1'b0;
        end else if (req) begin
            M_pc       <= HANDLER_PC;
            M_instr    <= 32'd0;
            M_bd       <= 1'b0;
            M_exc      <= 5'd0;
            M_res      <= 32'd0;
            M_rt_data  <= 32'd0;
            M_wa       <= 5'd0;
            M_is_load  <= 1'b0;
            M_is_store <= 1'b0;
            M_tnew     <= 2'd0;
            M_valid    <= 1'b0;
        end else if (bubble) begin
            // PC and bd ride along so an interrupt taken on the bubble
            // reports the stalled instruction as EPC.
            M_pc       <= E_pc;
            M_instr    <= 32'd0;
            M_bd       <= E_bd;
            M_exc      <= 5'd0;
            M_res      <= 32'd0;
            M_rt_data  <= 32'd0;
            M_wa       <= 5'd0;
            M_is_load  <= 1'b0;
            M_is_store <= 1'b0;
            M_tnew     <= 2'd0;
            M_valid    <= 1'b0;
        end else begin
            // A faulting instruction stays valid so CP0 can take it, but
            // loses its side effects (register write, memory access).
            M_pc       <= E_pc;
            M_instr    <= E_instr;
            M_bd       <= E_bd;
            M_exc      <= exc_merged;
            M_res      <= res_next;
            M_rt_data  <= E_rt_data;
            M_wa       <= has_exc ? 5'd0 : E_wa;
            M_is_load  <= has_exc ? 1'b0 : E_is_load;
            M_is_store <= has_exc ? 1'b0 : E_is_store;
            M_tnew     <= tnew_next;
            M_valid    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_em_stage_reg.sv
// tb/tb_em_stage_reg.sv - self-checking bench for em_stage_reg
module tb_em_stage_reg;

    typedef struct packed {
        logic        req, bubble;
        logic [31:0] pc, instr;
        logic        bd;
        logic [4:0]  exc;
        logic [31:0] alu;
        logic        ov, ovt, ld, st;
        logic [1:0]  sel;
        logic [31:0] hi, lo, rt;
        logic [4:0]  wa;
        logic [1:0]  tnew;
    } in_t;

    typedef struct packed {
        logic [31:0] pc, instr;
        logic        bd;
        logic [4:0]  exc;
        logic [31:0] res, rt;
        logic [4:0]  wa;
        logic        ld, st;
        logic [1:0]  tnew;
        logic        valid;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, req, bubble;
    logic [31:0] E_pc, E_instr, E_alu_res, E_HI, E_LO, E_rt_data;
    logic        E_bd, E_alu_ov, E_ov_trap, E_is_load, E_is_store;
    logic [4:0]  E_exc, E_wa;
    logic [1:0]  E_res_sel, E_tnew;
    logic [31:0] M_pc, M_instr, M_res, M_rt_data;
    logic        M_bd, M_is_load, M_is_store, M_valid;
    logic [4:0]  M_exc, M_wa;
    logic [1:0]  M_tnew;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    em_stage_reg dut (
        .clk(clk), .reset(reset), .req(req), .bubble(bubble),
        .E_pc(E_pc), .E_instr(E_instr), .E_bd(E_bd), .E_exc(E_exc),
        .E_alu_res(E_alu_res), .E_alu_ov(E_alu_ov), .E_ov_trap(E_ov_trap),
        .E_is_load(E_is_load), .E_is_store(E_is_store), .E_res_sel(E_res_sel),
        .E_HI(E_HI), .E_LO(E_LO), .E_rt_data(E_rt_data), .E_wa(E_wa),
        .E_tnew(E_tnew),
        .M_pc(M_pc), .M_instr(M_instr), .M_bd(M_bd), .M_exc(M_exc),
        .M_res(M_res), .M_rt_data(M_rt_data), .M_wa(M_wa),
        .M_is_load(M_is_load), .M_is_store(M_is_store), .M_tnew(M_tnew),
        .M_valid(M_valid)
    );

    task automatic drive(input in_t v);
        req = v.req;         bubble = v.bubble;
        E_pc = v.pc;         E_instr = v.instr;     E_bd = v.bd;
        E_exc = v.exc;       E_alu_res = v.alu;     E_alu_ov = v.ov;
        E_ov_trap = v.ovt;   E_is_load = v.ld;      E_is_store = v.st;
        E_res_sel = v.sel;   E_HI = v.hi;           E_LO = v.lo;
        E_rt_data = v.rt;    E_wa = v.wa;           E_tnew = v.tnew;
    endtask

    function automatic out_t sample();
        out_t o;
        o.pc = M_pc;   o.instr = M_instr; o.bd = M_bd;   o.exc = M_exc;
        o.res = M_res; o.rt = M_rt_data;  o.wa = M_wa;   o.ld = M_is_load;
        o.st = M_is_store; o.tnew = M_tnew; o.valid = M_valid;
        return o;
    endfunction

    function automatic in_t rand_in();
        in_t v;
        v.req = ($urandom_range(0, 15) == 0);
        v.bubble = ($urandom_range(0, 3) == 0);
        v.pc = $urandom;  v.instr = $urandom; v.bd = 1'($urandom);
        v.exc = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
        v.alu = $urandom; v.ov = 1'($urandom); v.ovt = 1'($urandom);
        v.ld = 1'($urandom); v.st = 1'($urandom); v.sel = 2'($urandom);
        v.hi = $urandom;  v.lo = $urandom; v.rt = $urandom;
        v.wa = 5'($urandom); v.tnew = 2'($urandom);
        return v;
    endfunction

    // Reference: the slot contents an M stage should hold after one edge.
    function automatic out_t model(input in_t v);
        out_t o;
        int   code;
        o = '0;
        if (v.req) begin
            o.pc = 32'h0000_4180;
        end else if (v.bubble) begin
            o.pc = v.pc;
            o.bd = v.bd;
        end else begin
            if (v.exc != 0)          code = v.exc;
            else if (!v.ov)          code = 0;
            else if (v.ovt)          code = 12;
            else if (v.ld)           code = 4;
            else if (v.st)           code = 5;
            else                     code = 0;
            o.pc = v.pc; o.instr = v.instr; o.bd = v.bd; o.rt = v.rt;
            o.exc = 5'(code);
            if (v.sel == 0)      o.res = v.alu;
            else if (v.sel == 1) o.res = v.hi;
            else if (v.sel == 2) o.res = v.lo;
            else                 o.res = 32'((64'(v.pc) + 64'd8) % 64'h1_0000_0000);
            o.wa = (code != 0) ? 5'd0 : v.wa;
            o.ld = (code != 0) ? 1'b0 : v.ld;
            o.st = (code != 0) ? 1'b0 : v.st;
            o.tnew = (v.tnew > 0) ? 2'(int'(v.tnew) - 1) : 2'd0;
            o.valid = 1'b1;
        end
        return o;
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input in_t v);
        @(negedge clk);
        reset = rst;
        drive(v);
        @(posedge clk);
        #1;
    endtask

    vec_t tab[$];
    vec_t t;
    in_t  v;
    out_t e;

    initial begin
        // Hand-derived vectors, one clock each.
        t = '{default: '0};
        t.i.pc = 32'h3000; t.i.instr = 32'h20; t.i.alu = 32'h1234; t.i.wa = 5'd3; t.i.rt = 32'hAA; t.i.tnew = 2'd1;
        t.o.pc = 32'h3000; t.o.instr = 32'h20; t.o.res = 32'h1234; t.o.wa = 5'd3; t.o.rt = 32'hAA; t.o.valid = 1'b1;
        tab.push_back(t);
        t = '{default: '0};
        t.i.pc = 32'h3004; t.i.sel = 2'd1; t.i.hi = 32'hDEADBEEF; t.i.alu = 32'h77; t.i.wa = 5'd4;
        t.o.pc = 32'h3004; t.o.res = 32'hDEADBEEF; t.o.wa = 5'd4; t.o.valid = 1'b1;
        tab.push_back(t);
        t = '{default: '0};
        t.i.pc = 32'h3008; t.i.sel = 2'd2; t.i.lo = 32'h5; t.i.hi = 32'h9; t.i.wa = 5'd5;
        t.o.pc = 32'h3008; t.o.res = 32'h5; t.o.wa = 5'd5; t.o.valid = 1'b1;
        tab.push_back(t);
        t = '{default: '0};
        t.i.pc = 32'h3010; t.i.sel = 2'd3; t.i.wa = 5'd31; t.i.tnew = 2'd3;
        t.o.pc = 32'h3010; t.o.res = 32'h3018; t.o.wa = 5'd31; t.o.tnew = 2'd2; t.o.valid = 1'b1;
        tab.push_back(t);
        t = '{default: '0};
        t.i.pc = 32'hFFFF_FFFC; t.i.sel = 2'd3;
        t.o.pc = 32'hFFFF_FFFC; t.o.res = 32'h4; t.o.valid = 1'b1;
        tab.push_back(t);
        t = '{default: '0};
        t.i.bubble = 1'b1; t.i.pc = 32'h3020; t.i.bd = 1'b1; t.i.wa = 5'd8; t.i.alu = 32'h99; t.i.ld = 1'b1; t.i.exc = 5'd7;
        t.o.pc = 32'h3020; t.o.bd = 1'b1;
        tab.push_back(t);
        t = '{default: '0};
        t.i.pc = 32'h3030; t.i.ov = 1'b1; t.i.ovt = 1'b1; t.i.wa = 5'd9; t.i.alu = 32'h7;
        t.o.pc = 32'h3030; t.o.exc = 5'd12; t.o.res = 32'h7; t.o.valid = 1'b1;
        tab.push_back(t);
        t = '{default: '0};
        t.i.pc = 32'h3034; t.i.exc = 5'd10; t.i.ov = 1'b1; t.i.ovt = 1'b1; t.i.wa = 5'd9;
        t.o.pc = 32'h3034; t.o.exc = 5'd10; t.o.valid = 1'b1;
        tab.push_back(t);
        t = '{default: '0};
        t.i.pc = 32'h3038; t.i.ov = 1'b1; t.i.ld = 1'b1; t.i.wa = 5'd2;
        t.o.pc = 32'h3038; t.o.exc = 5'd4; t.o.valid = 1'b1;
        tab.push_back(t);
        t = '{default: '0};
        t.i.pc = 32'h303C; t.i.ov = 1'b1; t.i.st = 1'b1; t.i.rt = 32'h55;
        t.o.pc = 32'h303C; t.o.exc = 5'd5; t.o.rt = 32'h55; t.o.valid = 1'b1;
        tab.push_back(t);
        t = '{default: '0};
        t.i.req = 1'b1; t.i.bubble = 1'b1; t.i.pc = 32'h3040; t.i.bd = 1'b1; t.i.wa = 5'd3; t.i.alu = 32'h1;
        t.o.pc = 32'h4180;
        tab.push_back(t);
        t = '{default: '0};
        t.i.pc = 32'h3044; t.i.ld = 1'b1; t.i.wa = 5'd6;
        t.o.pc = 32'h3044; t.o.ld = 1'b1; t.o.wa = 5'd6; t.o.valid = 1'b1;
        tab.push_back(t);
        t = '{default: '0};
        t.i.pc = 32'h3048; t.i.st = 1'b1; t.i.ovt = 1'b1;
        t.o.pc = 32'h3048; t.o.st = 1'b1; t.o.valid = 1'b1;
        tab.push_back(t);
        t = '{default: '0};
        t.i.pc = 32'h304C; t.i.ov = 1'b1; t.i.wa = 5'd7; t.i.alu = 32'h8000_0000;
        t.o.pc = 32'h304C; t.o.wa = 5'd7; t.o.res = 32'h8000_0000; t.o.valid = 1'b1;
        tab.push_back(t);
        t = '{default: '0};
        t.i.req = 1'b1; t.i.pc = 32'h3050; t.i.wa = 5'd4; t.i.instr = 32'h1;
        t.o.pc = 32'h4180;
        tab.push_back(t);
        t = '{default: '0};
        t.i.pc = 32'h3054; t.i.exc = 5'd3; t.i.bd = 1'b1; t.i.wa = 5'd4; t.i.st = 1'b1; t.i.ld = 1'b1;
        t.o.pc = 32'h3054; t.o.exc = 5'd3; t.o.bd = 1'b1; t.o.valid = 1'b1;
        tab.push_back(t);

        // Reset with random inputs, req asserted too: reset wins.
        v = rand_in();
        v.req = 1'b1;
        step(1'b1, v);
        check("reset", sample(), '0);

        foreach (tab[k]) begin
            step(1'b0, tab[k].i);
            check($sformatf("vec%0d", k), sample(), tab[k].o);
        end

        // Five-cycle stall: bubble carries PC/bd every cycle.
        v = '0; v.bubble = 1'b1; v.pc = 32'h3020; v.bd = 1'b1; v.wa = 5'd8;
        e = '0; e.pc = 32'h3020; e.bd = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step(1'b0, v);
            check($sformatf("stall%0d", c), sample(), e);
        end

        // tnew countdown across consecutive loads.
        for (int c = 0; c < 3; c++) begin
            v = '0; v.pc = 32'h3060; v.wa = 5'd1; v.tnew = 2'(2 - c);
            e = '0; e.pc = 32'h3060; e.wa = 5'd1; e.valid = 1'b1;
            e.tnew = (c == 0) ? 2'd1 : 2'd0;
            step(1'b0, v);
            check($sformatf("tnew%0d", c), sample(), e);
        end

        // Mid-operation reset, then recovery.
        step(1'b1, rand_in());
        check("mid_reset", sample(), '0);
        v = '0; v.pc = 32'h3010; v.sel = 2'd3;
        e = '0; e.pc = 32'h3010; e.res = 32'h3018; e.valid = 1'b1;
        step(1'b0, v);
        check("post_reset", sample(), e);

        // Randomized run against the reference.
        for (int c = 0; c < 400; c++) begin
            logic r;
            r = ($urandom_range(0, 31) == 0);
            v = rand_in();
            step(r, v);
            check($sformatf("rand%0d", c), sample(), r ? out_t'('0) : model(v));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
